// File: rtl/pingpong_wr_ctrl.sv
// Write-side ping-pong scheduler: steers fixed-length bursts alternately into FIFO A and FIFO B,
// stalling on full and holding at burst boundaries while the next buffer reports prog_full.
module pingpong_wr_ctrl #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned BCNT_W    = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    input  logic                 full_a,
    input  logic                 prog_full_a,
    input  logic                 full_b,
    input  logic                 prog_full_b,
    output logic                 wr_en_a,
    output logic                 wr_en_b,
    output logic [DATA_SIZE-1:0] wr_data,
    output logic                 sel,
    output logic                 burst_done,
    output logic                 hold,
    output logic [BCNT_W-1:0]    bursts_a,
    output logic [BCNT_W-1:0]    bursts_b
);

    typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

    localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BURST_LEN - 1);

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                burst_done_q, burst_done_d;
    logic [BCNT_W-1:0]   bursts_a_q, bursts_a_d;
    logic [BCNT_W-1:0]   bursts_b_q, bursts_b_d;

    logic full_cur, pf_cur, pf_next, acc, last;

    assign full_cur = sel_q ? full_b : full_a;
    assign pf_cur   = sel_q ? prog_full_b : prog_full_a;
    assign pf_next  = sel_q ? prog_full_a : prog_full_b;

    assign in_ready = (state_q == StFill) && !full_cur;
    assign acc      = in_valid && in_ready;
    assign last     = (beat_cnt_q == LastBeat);

    assign wr_en_a    = acc && !sel_q;
    assign wr_en_b    = acc && sel_q;
    assign wr_data    = in_data;
    assign sel        = sel_q;
    assign burst_done = burst_done_q;
    assign hold       = (state_q == StHold);
    assign bursts_a   = bursts_a_q;
    assign bursts_b   = bursts_b_q;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        beat_cnt_d   = beat_cnt_q;
        burst_done_d = 1'b0;
        bursts_a_d   = bursts_a_q;
        bursts_b_d   = bursts_b_q;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = pf_cur ? StHold : StFill;
                end
            end
            StFill: begin
                if (acc) begin
                    if (last) begin
                        beat_cnt_d   = '0;
                        sel_d        = ~sel_q;
                        burst_done_d = 1'b1;
                        if (sel_q) begin
                            bursts_b_d = bursts_b_q + 1'b1;
                        end else begin
                            bursts_a_d = bursts_a_q + 1'b1;
                        end
                        // Boundary decision looks at the buffer we are about to switch to.
                        if (!enable) begin
                            state_d = StIdle;
                        end else if (pf_next) begin
                            state_d = StHold;
                        end else begin
                            state_d = StFill;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            StHold: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (!pf_cur) begin
                    state_d = StFill;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= 1'b0;
            beat_cnt_q   <= '0;
            burst_done_q <= 1'b0;
            bursts_a_q   <= '0;
            bursts_b_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_done_q <= burst_done_d;
            bursts_a_q   <= bursts_a_d;
            bursts_b_q   <= bursts_b_d;
        end
    end

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Directed vector bench for pingpong_wr_ctrl: BURST_LEN=4 instance driven from a table,
// BURST_LEN=1 instance checked with a short hand-written sequence.
module tb_pingpong_wr_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned BW = 16;

    logic          clk = 1'b0;
    logic          rst, enable, in_valid, full_a, prog_full_a, full_b, prog_full_b;
    logic [DW-1:0] in_data;

    logic          rdy0, wa0, wb0, sel0, bd0, hd0;
    logic [DW-1:0] wd0;
    logic [BW-1:0] ba0, bb0;
    logic          rdy1, wa1, wb1, sel1, bd1, hd1;
    logic [DW-1:0] wd1;
    logic [BW-1:0] ba1, bb1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pingpong_wr_ctrl #(.DATA_SIZE(DW), .BURST_LEN(4), .CNT_W(2), .BCNT_W(BW)) dut4 (
        .wr_clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy0), .full_a(full_a), .prog_full_a(prog_full_a), .full_b(full_b),
        .prog_full_b(prog_full_b), .wr_en_a(wa0), .wr_en_b(wb0), .wr_data(wd0), .sel(sel0),
        .burst_done(bd0), .hold(hd0), .bursts_a(ba0), .bursts_b(bb0)
    );

    pingpong_wr_ctrl #(.DATA_SIZE(DW), .BURST_LEN(1), .CNT_W(2), .BCNT_W(BW)) dut1 (
        .wr_clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy1), .full_a(full_a), .prog_full_a(prog_full_a), .full_b(full_b),
        .prog_full_b(prog_full_b), .wr_en_a(wa1), .wr_en_b(wb1), .wr_data(wd1), .sel(sel1),
        .burst_done(bd1), .hold(hd1), .bursts_a(ba1), .bursts_b(bb1)
    );

    // in  = {rst, enable, in_valid, full_a, prog_full_a, full_b, prog_full_b}
    // out = {in_ready, wr_en_a, wr_en_b, sel, burst_done, hold}
    typedef struct {
        logic [6:0] in;
        logic [5:0] out;
        int         ba;
        int         bb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [6:0] in, input logic [5:0] out, input int ba, input int bb);
        vec_t v;
        v.in = in;
        v.out = out;
        v.ba = ba;
        v.bb = bb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0;
        full_a = 1'b0; prog_full_a = 1'b0; full_b = 1'b0; prog_full_b = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, then continuous alternation with a mid-burst prog_full_a glitch.
        add(7'b1000000, 6'b000000, 0, 0);
        add(7'b0110000, 6'b000000, 0, 0);
        add(7'b0110000, 6'b110000, 0, 0);
        add(7'b0110100, 6'b110000, 0, 0);
        add(7'b0110000, 6'b110000, 0, 0);
        add(7'b0110000, 6'b110000, 0, 0);
        add(7'b0110000, 6'b101110, 1, 0);
        for (int i = 0; i < 3; i++) add(7'b0110000, 6'b101100, 1, 0);
        add(7'b0110000, 6'b110010, 1, 1);
        for (int i = 0; i < 3; i++) add(7'b0110000, 6'b110000, 1, 1);
        add(7'b0110000, 6'b101110, 2, 1);
        for (int i = 0; i < 3; i++) add(7'b0110000, 6'b101100, 2, 1);
        add(7'b0110000, 6'b110010, 2, 2);
        add(7'b0110000, 6'b110000, 2, 2);
        // full_a stall for 3 cycles mid-burst A.
        for (int i = 0; i < 3; i++) add(7'b0111000, 6'b000000, 2, 2);
        add(7'b0110000, 6'b110000, 2, 2);
        // prog_full_b at the end of burst A forces HOLD until it drops.
        add(7'b0110001, 6'b110000, 2, 2);
        add(7'b0110001, 6'b000111, 3, 2);
        add(7'b0110001, 6'b000101, 3, 2);
        add(7'b0110000, 6'b000101, 3, 2);
        for (int i = 0; i < 4; i++) add(7'b0110000, 6'b101100, 3, 2);
        // enable dropped after word 2 of burst A: burst completes, then IDLE with sel=1.
        add(7'b0110000, 6'b110010, 3, 3);
        add(7'b0110000, 6'b110000, 3, 3);
        add(7'b0010000, 6'b110000, 3, 3);
        add(7'b0010000, 6'b110000, 3, 3);
        add(7'b0010000, 6'b000110, 4, 3);
        add(7'b0010000, 6'b000100, 4, 3);
        add(7'b0110000, 6'b000100, 4, 3);
        add(7'b0110000, 6'b101100, 4, 3);
        add(7'b0110000, 6'b101100, 4, 3);
        // Reset mid-burst B.
        add(7'b1100000, 6'b100100, 4, 3);
        add(7'b0010000, 6'b000000, 0, 0);
        // IDLE -> HOLD on prog_full_a, HOLD -> IDLE on enable drop.
        add(7'b0100100, 6'b000000, 0, 0);
        add(7'b0100100, 6'b000001, 0, 0);
        add(7'b0000100, 6'b000001, 0, 0);
        add(7'b0000000, 6'b000000, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            {rst, enable, in_valid, full_a, prog_full_a, full_b, prog_full_b} = vecs[i].in;
            in_data = DW'($urandom);
            #1;
            check($sformatf("v%0d in_ready", i), 32'(rdy0), 32'(vecs[i].out[5]));
            check($sformatf("v%0d wr_en_a", i), 32'(wa0), 32'(vecs[i].out[4]));
            check($sformatf("v%0d wr_en_b", i), 32'(wb0), 32'(vecs[i].out[3]));
            check($sformatf("v%0d sel", i), 32'(sel0), 32'(vecs[i].out[2]));
            check($sformatf("v%0d burst_done", i), 32'(bd0), 32'(vecs[i].out[1]));
            check($sformatf("v%0d hold", i), 32'(hd0), 32'(vecs[i].out[0]));
            check($sformatf("v%0d bursts_a", i), 32'(ba0), 32'(vecs[i].ba));
            check($sformatf("v%0d bursts_b", i), 32'(bb0), 32'(vecs[i].bb));
            if (vecs[i].out[4] || vecs[i].out[3]) begin
                check($sformatf("v%0d wr_data", i), 32'(wd0), 32'(in_data));
            end
        end

        // BURST_LEN=1: six back-to-back words alternate A,B,... with burst_done every cycle.
        @(negedge clk);
        {rst, enable, in_valid, full_a, prog_full_a, full_b, prog_full_b} = 7'b1000000;
        @(negedge clk);
        {rst, enable, in_valid} = 3'b011;
        #1;
        check("bl1 idle wr_en", 32'({wa1, wb1}), 32'(0));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("bl1 w%0d wr_en_a", k), 32'(wa1), 32'(k % 2));
            check($sformatf("bl1 w%0d wr_en_b", k), 32'(wb1), 32'((k + 1) % 2));
            check($sformatf("bl1 w%0d burst_done", k), 32'(bd1), 32'(k >= 2));
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bl1 final burst_done", 32'(bd1), 32'(1));
        check("bl1 final sel", 32'(sel1), 32'(0));
        check("bl1 bursts_a", 32'(ba1), 32'(3));
        check("bl1 bursts_b", 32'(bb1), 32'(3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
